// File: rtl/bcd_digit_entry.sv
// Debounces keypad presses and assembles accepted BCD digits into a packed entry word.
// Latency: 1-cycle input register, DEBOUNCE cycles of registered chk, then store and strobe on the next edge.
// Backpressure: no wrap; when full, presses raise err until consume, clr, del or rst frees space.
module bcd_digit_entry #(
  parameter int NUM_DIGITS = 4,
  parameter int DEBOUNCE   = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    chk,
  input  logic [3:0]              digit,
  input  logic                    clr,
  input  logic                    del,
  input  logic                    consume,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic [2:0]              count,
  output logic                    full,
  output logic                    key_strobe,
  output logic                    err
);

  localparam logic [7:0] DB_LIM = 8'(DEBOUNCE);
  localparam logic [2:0] N_CNT  = 3'(NUM_DIGITS);

  typedef enum logic [1:0] {IDLE, ARM, HELD} state_t;

  state_t                  state, state_nxt;
  logic [7:0]              db_cnt, db_cnt_nxt;
  logic                    accept;
  logic                    chk_q;
  logic [3:0]              digit_q;
  logic                    do_consume, do_del, act_ok, store, reject;
  logic [4*NUM_DIGITS-1:0] bcd_push;

  // Register the encoder outputs once before they reach the debouncer.
  always_ff @(posedge clk) begin
    if (rst) begin
      chk_q   <= 1'b0;
      digit_q <= 4'h0;
    end else begin
      chk_q   <= chk;
      digit_q <= digit;
    end
  end

  // Debounce state and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      db_cnt <= 8'd0;
    end else begin
      state  <= state_nxt;
      db_cnt <= db_cnt_nxt;
    end
  end

  // Debounce next-state: one accept per press, released only by chk dropping.
  always_comb begin
    state_nxt  = state;
    db_cnt_nxt = db_cnt;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (chk_q) begin
          if (DB_LIM == 8'd1) begin
            accept     = 1'b1;
            state_nxt  = HELD;
            db_cnt_nxt = 8'd0;
          end else begin
            state_nxt  = ARM;
            db_cnt_nxt = 8'd1;
          end
        end
      end
      ARM: begin
        if (!chk_q) begin
          state_nxt  = IDLE;
          db_cnt_nxt = 8'd0;
        end else if (db_cnt + 8'd1 == DB_LIM) begin
          accept     = 1'b1;
          state_nxt  = HELD;
          db_cnt_nxt = 8'd0;
        end else begin
          db_cnt_nxt = db_cnt + 8'd1;
        end
      end
      HELD: begin
        if (!chk_q) state_nxt = IDLE;
      end
      default: begin
        state_nxt  = IDLE;
        db_cnt_nxt = 8'd0;
      end
    endcase
  end

  // New digit shifts in at the bottom so the first entered ends up on top.
  generate
    if (NUM_DIGITS == 1) begin : g_one
      assign bcd_push = digit_q;
    end else begin : g_many
      assign bcd_push = {bcd[4*NUM_DIGITS-5:0], digit_q};
    end
  endgenerate

  assign full       = (count == N_CNT);
  assign do_consume = consume && full;
  assign do_del     = del && (count != 3'd0);
  // An accept shadowed by a higher-priority buffer operation is silently dropped.
  assign act_ok     = accept && !clr && !do_consume && !do_del;
  assign store      = act_ok && (digit_q <= 4'd9) && !full;
  assign reject     = act_ok && !((digit_q <= 4'd9) && !full);

  // Entry buffer update in priority order clr > consume > del > accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      bcd        <= '0;
      count      <= 3'd0;
      key_strobe <= 1'b0;
      err        <= 1'b0;
    end else begin
      key_strobe <= store;
      err        <= reject;
      if (clr || do_consume) begin
        bcd   <= '0;
        count <= 3'd0;
      end else if (do_del) begin
        bcd   <= bcd >> 4;
        count <= count - 3'd1;
      end else if (store) begin
        bcd   <= bcd_push;
        count <= count + 3'd1;
      end
    end
  end

endmodule
